// File: rtl/snn_weight_mem_ctrl.sv
// snn_weight_mem_ctrl: arbiter/sequencer for the single port of the
// 16x8 synaptic weight memory shared by neuron scan and reward update.
//
// Ports:
//   clk, rst_n            clock, async active-low reset
//   scan_start            pulse: request a full sequential weight scan
//   scan_valid/addr/data  one delivered weight per beat
//   scan_done             high with the last scan beat
//   upd_req/addr/delta    level request for a saturating weight update
//   upd_ack               pulse in the cycle the updated weight is written
//   busy                  controller is not idle
//   mem_addr/we/wdata     memory command lines
//   mem_rdata             registered memory read data (1-cycle latency)

module snn_weight_mem_ctrl #(
    parameter int ADDR_W = 4,
    parameter int DATA_W = 8,
    parameter int DEPTH  = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              scan_start,
    output logic              scan_valid,
    output logic [ADDR_W-1:0] scan_addr,
    output logic [DATA_W-1:0] scan_data,
    output logic              scan_done,
    input  logic              upd_req,
    input  logic [ADDR_W-1:0] upd_addr,
    input  logic [DATA_W-1:0] upd_delta,
    output logic              upd_ack,
    output logic              busy,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_we,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata
);

    typedef enum logic [2:0] {
        IDLE,
        SCAN,
        SCAN_TAIL,
        UPD_RD,
        UPD_WR
    } state_t;

    localparam logic [ADDR_W-1:0] LAST = ADDR_W'(DEPTH - 1);

    state_t              state_q, state_d;
    logic [ADDR_W-1:0]   cnt_q, cnt_d;
    logic                pend_q, pend_d;
    logic                last_upd_q, last_upd_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [DATA_W-1:0]   delta_q, delta_d;
    logic                valid_q;
    logic [ADDR_W-1:0]   saddr_q;
    logic                scan_c;
    logic [DATA_W+1:0]   sum;
    logic [DATA_W-1:0]   sat_val;

    // Two extra bits hold both the sign and the carry of the sum.
    assign sum = {2'b00, mem_rdata}
               + {{2{delta_q[DATA_W-1]}}, delta_q};

    always_comb begin
        sat_val = sum[DATA_W-1:0];
        if (sum[DATA_W+1]) begin
            sat_val = '0;
        end else if (sum[DATA_W]) begin
            sat_val = '1;
        end
    end

    assign scan_c = scan_start | pend_q;

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        pend_d     = pend_q;
        last_upd_d = last_upd_q;
        addr_d     = addr_q;
        delta_d    = delta_q;
        mem_addr   = '0;
        mem_we     = 1'b0;
        mem_wdata  = '0;
        upd_ack    = 1'b0;
        if (state_q != IDLE) begin
            pend_d = pend_q | scan_start;
        end
        unique case (state_q)
            IDLE: begin
                // A start that loses the tie stays pending.
                pend_d = scan_c;
                if (scan_c && (!upd_req || last_upd_q)) begin
                    state_d    = SCAN;
                    cnt_d      = '0;
                    pend_d     = 1'b0;
                    last_upd_d = 1'b0;
                end else if (upd_req) begin
                    state_d    = UPD_RD;
                    addr_d     = upd_addr;
                    delta_d    = upd_delta;
                    last_upd_d = 1'b1;
                end
            end
            SCAN: begin
                mem_addr = cnt_q;
                cnt_d    = cnt_q + ADDR_W'(1);
                if (cnt_q == LAST) begin
                    state_d = SCAN_TAIL;
                end
            end
            SCAN_TAIL: begin
                state_d = IDLE;
            end
            UPD_RD: begin
                mem_addr = addr_q;
                state_d  = UPD_WR;
            end
            UPD_WR: begin
                mem_addr  = addr_q;
                mem_we    = 1'b1;
                mem_wdata = sat_val;
                upd_ack   = 1'b1;
                state_d   = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            pend_q     <= 1'b0;
            last_upd_q <= 1'b0;
            addr_q     <= '0;
            delta_q    <= '0;
            valid_q    <= 1'b0;
            saddr_q    <= '0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            pend_q     <= pend_d;
            last_upd_q <= last_upd_d;
            addr_q     <= addr_d;
            delta_q    <= delta_d;
            valid_q    <= (state_q == SCAN);
            saddr_q    <= cnt_q;
        end
    end

    // Read data lags the address by one cycle, so the beat is
    // tagged with the address issued in the previous cycle.
    assign scan_valid = valid_q;
    assign scan_addr  = valid_q ? saddr_q : '0;
    assign scan_data  = valid_q ? mem_rdata : '0;
    assign scan_done  = (state_q == SCAN_TAIL);
    assign busy       = (state_q != IDLE);

endmodule

// File: tb/tb_snn_weight_mem_ctrl.sv
// tb_snn_weight_mem_ctrl: directed bench with a timeline-level
// reference model of the weight memory controller.

module tb_snn_weight_mem_ctrl;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       scan_start = 1'b0;
    logic       upd_req = 1'b0;
    logic [3:0] upd_addr = '0;
    logic [7:0] upd_delta = '0;
    logic       scan_valid, scan_done, upd_ack, busy, mem_we;
    logic [3:0] scan_addr, mem_addr;
    logic [7:0] scan_data, mem_wdata, mem_rdata;

    always #5 clk = ~clk;

    snn_weight_mem_ctrl #(
        .ADDR_W(4),
        .DATA_W(8),
        .DEPTH(16)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .scan_start(scan_start),
        .scan_valid(scan_valid),
        .scan_addr(scan_addr),
        .scan_data(scan_data),
        .scan_done(scan_done),
        .upd_req(upd_req),
        .upd_addr(upd_addr),
        .upd_delta(upd_delta),
        .upd_ack(upd_ack),
        .busy(busy),
        .mem_addr(mem_addr),
        .mem_we(mem_we),
        .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata)
    );

    // Weight memory with a bench-side preload port.
    logic [7:0] mem [16];
    logic       pl_clr = 1'b1;
    logic       pl_we = 1'b0;
    logic [3:0] pl_addr = '0;
    logic [7:0] pl_data = '0;

    always @(posedge clk) begin
        if (pl_clr) begin
            for (int i = 0; i < 16; i++) mem[i] <= 8'h00;
        end else if (pl_we) begin
            mem[pl_addr] <= pl_data;
        end else if (mem_we) begin
            mem[mem_addr] <= mem_wdata;
        end
        mem_rdata <= mem[mem_addr];
    end

    int total = 0;
    int bad = 0;

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h @%0t", nm, act, exp, $time);
        end
    endtask

    function automatic int sat(input int rd, input logic [7:0] d);
        int s;
        s = rd + int'($signed(d));
        if (s < 0) return 0;
        if (s > 255) return 255;
        return s;
    endfunction

    // Model: op 0 none, 1 scan, 2 update; age counts cycles since grant.
    int         op = 0;
    int         age = 0;
    bit         pend = 0;
    bit         last_upd = 0;
    logic [3:0] m_addr = '0;
    logic [7:0] m_delta = '0;
    int         ref_mem [16];
    byte        evq [$];
    logic [7:0] seen [16];
    int         n_valid = 0;
    int         n_done = 0;

    initial begin : compare
        bit idle_prev, sc;
        int e_busy, e_addr, e_we, e_wdata, e_ack;
        int e_valid, e_saddr, e_sdata, e_done;
        forever begin
            @(posedge clk);
            #2;
            if (!rst_n) begin
                op = 0; age = 0; pend = 0; last_upd = 0;
            end else begin
                idle_prev = (op == 0);
                if (!idle_prev) begin
                    if (scan_start) pend = 1;
                    age++;
                    if ((op == 1 && age == 18) || (op == 2 && age == 3)) begin
                        op = 0; age = 0;
                    end
                end else begin
                    sc = scan_start || pend;
                    if (sc && (!upd_req || last_upd)) begin
                        op = 1; age = 1; pend = 0; last_upd = 0;
                    end else if (upd_req) begin
                        op = 2; age = 1; pend = sc; last_upd = 1;
                        m_addr = upd_addr; m_delta = upd_delta;
                    end else begin
                        pend = 0;
                    end
                end
            end
            e_busy = (op != 0) ? 1 : 0;
            e_addr = 0; e_we = 0; e_wdata = 0; e_ack = 0;
            e_valid = 0; e_saddr = 0; e_sdata = 0; e_done = 0;
            if (op == 1) begin
                if (age <= 16) e_addr = age - 1;
                if (age >= 2) begin
                    e_valid = 1;
                    e_saddr = age - 2;
                    e_sdata = ref_mem[age-2];
                end
                if (age == 17) e_done = 1;
            end else if (op == 2) begin
                e_addr = int'(m_addr);
                if (age == 2) begin
                    e_we = 1; e_ack = 1;
                    e_wdata = sat(ref_mem[m_addr], m_delta);
                end
            end
            chk("busy", busy, e_busy);
            chk("mem_addr", mem_addr, e_addr);
            chk("mem_we", mem_we, e_we);
            chk("mem_wdata", mem_wdata, e_wdata);
            chk("upd_ack", upd_ack, e_ack);
            chk("scan_valid", scan_valid, e_valid);
            chk("scan_addr", scan_addr, e_saddr);
            chk("scan_data", scan_data, e_sdata);
            chk("scan_done", scan_done, e_done);
            if (upd_ack) evq.push_back("U");
            if (scan_done) begin evq.push_back("S"); n_done++; end
            if (scan_valid) begin seen[scan_addr] = scan_data; n_valid++; end
            if (op == 2 && age == 2) ref_mem[m_addr] = e_wdata;
        end
    end

    function automatic byte ev(input int i);
        return (evq.size() > i) ? evq[i] : 8'd0;
    endfunction

    task automatic wait_quiet();
        int q = 0;
        int n = 0;
        while (q < 3 && n < 300) begin
            @(negedge clk);
            n++;
            if (busy) q = 0; else q++;
        end
        chk("quiet_timeout", q, 3);
    endtask

    task automatic wait_ack();
        int n = 0;
        while (!upd_ack && n < 60) begin
            @(negedge clk);
            n++;
        end
        chk("ack_wait", upd_ack, 1);
        upd_req = 1'b0;
    endtask

    task automatic upd(input logic [3:0] a, input logic [7:0] d,
                       output int lat);
        @(negedge clk);
        upd_req = 1'b1; upd_addr = a; upd_delta = d;
        lat = 0;
        do begin
            @(negedge clk);
            lat++;
        end while (!upd_ack && lat < 60);
        upd_req = 1'b0;
        chk("ack_seen", upd_ack, 1);
    endtask

    task automatic preload(input logic [3:0] a, input logic [7:0] v);
        @(negedge clk);
        pl_we = 1'b1; pl_addr = a; pl_data = v;
        ref_mem[a] = int'(v);
        @(negedge clk);
        pl_we = 1'b0;
    endtask

    task automatic pulse_scan();
        @(negedge clk) scan_start = 1'b1;
        @(negedge clk) scan_start = 1'b0;
    endtask

    task automatic reset_pulse();
        @(negedge clk) rst_n = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin : stim
        int lat;
        int bc;
        for (int i = 0; i < 16; i++) ref_mem[i] = 0;
        repeat (3) @(negedge clk);
        chk("rst_busy", busy, 0);
        chk("rst_valid", scan_valid, 0);
        chk("rst_we", mem_we, 0);
        chk("rst_ack", upd_ack, 0);
        pl_clr = 1'b0;
        rst_n = 1'b1;

        // Full scan of a cleared memory.
        n_valid = 0; n_done = 0;
        @(negedge clk) scan_start = 1'b1;
        @(negedge clk) scan_start = 1'b0;
        bc = 0;
        while (busy && bc < 100) begin
            bc++;
            @(negedge clk);
        end
        chk("scan_busy_cycles", bc, 17);
        wait_quiet();
        chk("scan_beats", n_valid, 16);
        chk("scan_done_cnt", n_done, 1);
        chk("scan_w15", seen[15], 8'h00);

        // Positive update then read back by scan.
        preload(4'd5, 8'h10);
        upd(4'd5, 8'h20, lat);
        chk("ack_latency", lat, 2);
        wait_quiet();
        chk("mem5", mem[5], 8'h30);
        pulse_scan();
        wait_quiet();
        chk("scan_w5", seen[5], 8'h30);

        // Saturation cases.
        preload(4'd3, 8'hF0);
        upd(4'd3, 8'h20, lat);
        wait_quiet();
        chk("sat_hi", mem[3], 8'hFF);
        preload(4'd3, 8'h05);
        upd(4'd3, 8'hF0, lat);
        wait_quiet();
        chk("sat_lo", mem[3], 8'h00);
        preload(4'd3, 8'h80);
        upd(4'd3, 8'hFF, lat);
        wait_quiet();
        chk("sub_one", mem[3], 8'h7F);

        // Simultaneous requests after reset: update wins first.
        reset_pulse();
        evq.delete();
        @(negedge clk);
        scan_start = 1'b1; upd_req = 1'b1;
        upd_addr = 4'd1; upd_delta = 8'h07;
        @(negedge clk) scan_start = 1'b0;
        wait_ack();
        wait_quiet();
        chk("tie_n", evq.size(), 2);
        chk("tie_0", ev(0), "U");
        chk("tie_1", ev(1), "S");
        chk("tie_mem1", mem[1], 8'h07);

        // Update raised mid-scan waits for scan_done.
        evq.delete();
        pulse_scan();
        repeat (4) @(negedge clk);
        upd_req = 1'b1; upd_addr = 4'd7; upd_delta = 8'h01;
        wait_ack();
        wait_quiet();
        chk("midscan_0", ev(0), "S");
        chk("midscan_1", ev(1), "U");

        // Scan pulsed mid-update is held pending.
        evq.delete();
        @(negedge clk);
        upd_req = 1'b1; upd_addr = 4'd8; upd_delta = 8'h02;
        @(negedge clk) scan_start = 1'b1;
        @(negedge clk) scan_start = 1'b0;
        wait_ack();
        wait_quiet();
        chk("midupd_n", evq.size(), 2);
        chk("midupd_0", ev(0), "U");
        chk("midupd_1", ev(1), "S");

        // Fairness under constant contention.
        reset_pulse();
        evq.delete();
        @(negedge clk);
        upd_req = 1'b1; upd_addr = 4'd9; upd_delta = 8'h01;
        scan_start = 1'b1;
        bc = 0;
        while (evq.size() < 4 && bc < 200) begin
            @(negedge clk);
            bc++;
        end
        upd_req = 1'b0; scan_start = 1'b0;
        wait_quiet();
        chk("fair_0", ev(0), "U");
        chk("fair_1", ev(1), "S");
        chk("fair_2", ev(2), "U");
        chk("fair_3", ev(3), "S");
        chk("fair_mem9", mem[9], 8'h02);

        // Reset during UPD_RD: no write may land.
        preload(4'd2, 8'h44);
        @(negedge clk);
        upd_req = 1'b1; upd_addr = 4'd2; upd_delta = 8'h05;
        @(negedge clk);
        chk("updrd_busy", busy, 1);
        rst_n = 1'b0;
        #1;
        chk("rstupd_we", mem_we, 0);
        chk("rstupd_busy", busy, 0);
        chk("rstupd_addr", mem_addr, 0);
        upd_req = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        wait_quiet();
        chk("rstupd_mem2", mem[2], 8'h44);

        // Reset at scan beat 7.
        n_done = 0;
        @(negedge clk) scan_start = 1'b1;
        @(negedge clk) scan_start = 1'b0;
        repeat (7) @(negedge clk);
        chk("beat7_valid", scan_valid, 1);
        chk("beat7_addr", scan_addr, 4'd6);
        rst_n = 1'b0;
        #1;
        chk("rstscan_valid", scan_valid, 0);
        chk("rstscan_done", scan_done, 0);
        chk("rstscan_data", scan_data, 0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        wait_quiet();
        chk("rstscan_nodone", n_done, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
